alu_exec_unit: RTL and testbench

// - Execute-stage ALU; consumes the 4-bit ALU_control code from the ALU decoder plus two operands.
// - Logic/add/sub/shift/compare ops complete with 1-cycle registered latency.
// - MUL (code 4'b1110) runs as an iterative radix-2 shift-add multiplier.
// - busy stalls PC/register write-back in the CPU while a MUL is in flight.

---
 rtl/alu_exec_unit_if.sv | 24 ++
 rtl/alu_exec_unit.sv | 137 +++++++++++++
 tb/tb_alu_exec_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshake and data bundle between the ALU decoder/CPU (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, ALU_control, src_a, src_b,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, ALU_control, src_a, src_b,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus an iterative shift-add MUL.
// Define MUL_EARLY_EXIT_EN to let MUL finish as soon as the remaining multiplier bits are all zero.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;

    logic             accept_op, accept_mul, mul_done;
    logic [WIDTH-1:0] acc_step, mplier_step, op_result;
    logic [SH_W-1:0]  shamt;

    assign shamt = bus.src_b[SH_W-1:0];

    always_comb begin
        op_result = '0;
        case (bus.ALU_control)
            OP_AND:  op_result = bus.src_a & bus.src_b;
            OP_OR:   op_result = bus.src_a | bus.src_b;
            OP_XOR:  op_result = bus.src_a ^ bus.src_b;
            OP_ADD:  op_result = bus.src_a + bus.src_b;
            OP_SUB:  op_result = bus.src_a - bus.src_b;
            OP_SLL:  op_result = bus.src_a << shamt;
            OP_SRL:  op_result = bus.src_a >> shamt;
            OP_SRA:  op_result = $signed(bus.src_a) >>> shamt;
            OP_SLTU: op_result = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            default: op_result = '0;
        endcase
    end

    // The last iteration's sum is written straight to result, so no extra drain cycle.
    always_comb begin
        state_next  = state;
        accept_op   = 1'b0;
        accept_mul  = 1'b0;
        mul_done    = 1'b0;
        acc_step    = acc + (mplier[0] ? mcand : '0);
        mplier_step = mplier >> 1;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.ALU_control == OP_MUL) begin
                        accept_mul = 1'b1;
                        state_next = MUL;
                    end else begin
                        accept_op = 1'b1;
                    end
                end
            end
            MUL: begin
`ifdef MUL_EARLY_EXIT_EN
                mul_done = (cnt == CNT_W'(1)) || (mplier_step == '0);
`else
                mul_done = (cnt == CNT_W'(1));
`endif
                if (mul_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept_op) begin
                result_q    <= op_result;
                zero_q      <= (op_result == '0);
                out_valid_q <= 1'b1;
            end
            if (accept_mul) begin
                acc    <= '0;
                mcand  <= bus.src_a;
                mplier <= bus.src_b;
                cnt    <= CNT_W'(WIDTH);
            end
            if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier_step;
                cnt    <= cnt - CNT_W'(1);
                if (mul_done) begin
                    result_q    <= acc_step;
                    zero_q      <= (acc_step == '0);
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == MUL);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases, reset abort mid-MUL, then random ops
// against an arithmetic reference model. Honors MUL_EARLY_EXIT_EN for MUL latency expectations.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   busy_from = 0;
    int   busy_to = 0;
    bit   check_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0] refModel(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        int unsigned       sh;
        logic signed [31:0] sa;
        logic [63:0]       p;
        sh = b % 32;
        sa = a;
        p  = {32'b0, a} * {32'b0, b};
        case (code)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return sa >>> sh;
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd14:   return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    // Number of MUL clock edges between accept and the result becoming visible.
    function automatic int mulIters(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
        if (b == 0) return 1;
        for (int i = 31; i >= 0; i--)
            if (b[i]) return i + 1;
        return 1;
`else
        return WIDTH;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at a negedge; holds the op until accepted, then returns at the following negedge.
    task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input string name);
        int   waited;
        int   acc_edge;
        int   iters;
        exp_t e;
        bus.in_valid    = 1'b1;
        bus.ALU_control = code;
        bus.src_a       = a;
        bus.src_b       = b;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL %s accept timeout: in_ready=%0b expected 1", name, bus.in_ready);
            return;
        end
        acc_edge = edge_cnt + 1;
        iters    = (code == 4'd14) ? mulIters(b) : 0;
        e.res    = refModel(code, a, b);
        e.zero   = (e.res == 0);
        e.due    = acc_edge + iters;
        e.name   = name;
        sb.push_back(e);
        if (code == 4'd14) begin
            busy_from = acc_edge;
            busy_to   = acc_edge + iters;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en && !reset) begin
            checkOutput("busy", 32'(bus.busy), 32'(edge_cnt >= busy_from && edge_cnt < busy_to));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(!(edge_cnt >= busy_from && edge_cnt < busy_to)));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious out_valid: got result 0x%08h expected no output", bus.result);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, " result"}, bus.result, mon_e.res);
                    checkOutput({mon_e.name, " zero"}, 32'(bus.zero), 32'(mon_e.zero));
                    checkOutput({mon_e.name, " latency edge"}, edge_cnt, mon_e.due);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  code;
        logic [31:0] a, b;
        int          waited;

        bus.in_valid    = 1'b0;
        bus.ALU_control = 4'd0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        reset           = 1'b1;
        #12;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset result", bus.result, 32'd0);
        checkOutput("reset zero", 32'(bus.zero), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset    = 1'b0;
        check_en = 1'b1;
        idle(2);

        applyStimulus(4'd3, 32'hFFFF_FFFF, 32'd1, "ADD wrap");
        idle(1);
        applyStimulus(4'd4, 32'd5, 32'd5, "SUB 5-5");
        applyStimulus(4'd7, 32'h8000_0000, 32'h21, "SRA shamt1");
        applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd1, "SLT -1<1");
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd1, "SLTU max<1");
        applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, "unknown op");
        idle(1);
        applyStimulus(4'd14, 32'd7, 32'd6, "MUL 7*6");
        applyStimulus(4'd1, 32'hDEAD_0000, 32'h0000_BEEF, "OR held during MUL");
        applyStimulus(4'd14, 32'h8000_0001, 32'd2, "MUL wrap");
        idle(1);
        applyStimulus(4'd14, 32'h1234_5678, 32'd0, "MUL by 0");
        applyStimulus(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, "AND b2b");
        applyStimulus(4'd1, 32'hF0F0_F0F0, 32'h0F0F_0000, "OR b2b");
        applyStimulus(4'd2, 32'hAAAA_AAAA, 32'hFFFF_0000, "XOR b2b");
        idle(3);

        // Abort a multiply part-way through and make sure it never reports.
        applyStimulus(4'd14, 32'd7, 32'd6, "MUL aborted");
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort result", bus.result, 32'd0);
        checkOutput("abort zero", 32'(bus.zero), 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        busy_from = 0;
        busy_to   = 0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        check_en = 1'b1;
        idle(40);

        for (int n = 0; n < 60; n++) begin
            code = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'd0;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom_range(0, 40);
            endcase
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'd0;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom_range(0, 40);
            endcase
            applyStimulus(code, a, b, $sformatf("rand%0d op%0d", n, code));
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end

        bus.in_valid = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain pending", sb.size(), 32'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
